spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
- Shares one external QSPI RAM command port (ram0 or ram1 controller) between two requesters:
  - the flash-emulation read path ("emu"): latency critical, read-only, open-ended until the flash chip-select deasserts;
  - the host/UART load path ("host"): bounded reads/writes, used to fill and inspect the emulated image.
- Emu has fixed priority. A starvation counter guarantees host forward progress.
- Sits between the spi-spy front end and the per-RAM command sequencer.

Parameters:
- ADDR_BITS, 24, byte address width for both requesters and the RAM command.
- LEN_BITS, 16, host transfer length width, in bytes.
- STARVE_LIMIT, 1024, cycles host_req may wait while emu wins before host is forced next.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- emu_req  input  1  emu wants a read stream; level, held until emu_done
- emu_addr  input  ADDR_BITS  start address, sampled on grant
- emu_abort  input  1  emu stream end (CS high); pulse
- emu_grant  output  1  emu owns the RAM port
- emu_rd_strobe  output  1  rd_data valid for emu
- emu_done  output  1  one-cycle pulse, emu transaction retired
- host_req  input  1  host transaction request; level, held until host_done
- host_addr  input  ADDR_BITS  start address, sampled on grant
- host_len  input  LEN_BITS  byte count, sampled on grant
- host_write  input  1  1 = write, 0 = read; sampled on grant
- host_wr_data  input  8  write byte, must be valid when host_wr_take pulses
- host_grant  output  1  host owns the RAM port
- host_rd_strobe  output  1  rd_data valid for host
- host_wr_take  output  1  host_wr_data consumed this cycle
- host_done  output  1  one-cycle pulse, host transaction retired
- rd_data  output  8  read byte broadcast; registered copy of ram_rd_data
- ram_cmd_valid  output  1  command valid
- ram_cmd_ready  input  1  sequencer accepts command
- ram_cmd_addr  output  ADDR_BITS  command address
- ram_cmd_len  output  LEN_BITS  byte count; 0 = open-ended
- ram_cmd_write  output  1  command is a write
- ram_cmd_abort  output  1  terminate open/in-flight transfer
- ram_rd_data  input  8  read byte from sequencer
- ram_rd_strobe  input  1  ram_rd_data valid
- ram_wr_take  input  1  sequencer consumes ram_wr_data
- ram_wr_data  output  8  combinational pass-through of host_wr_data
- ram_done  input  1  sequencer finished, including after abort

Behaviour:
- Reset: state IDLE; all outputs 0; starve counter 0; cmd registers 0. Reset mid-transaction drops everything immediately. The sequencer is reset by the same reset_n.
- States: IDLE, ISSUE_EMU, ISSUE_HOST, BUSY_EMU, BUSY_HOST, DRAIN.
- IDLE transitions:
  - emu_req and not (host_req and starve==STARVE_LIMIT) → ISSUE_EMU.
  - Else host_req → ISSUE_HOST.
  - Decision registered; ram_cmd_valid rises 1 cycle after the request is seen.
- ISSUE_EMU:
  - grant=1, cmd_valid=1, len=0, write=0.
  - On cmd_ready → BUSY_EMU.
  - emu_abort before ready → drop cmd_valid, pulse emu_done, → IDLE. No RAM access.
- ISSUE_HOST:
  - grant=1, cmd_valid=1, len=host_len, write=host_write.
  - On cmd_ready → BUSY_HOST.
  - host_len==0 → skip the RAM command; pulse host_done next cycle; → IDLE.
- cmd_valid, addr, len and write are held stable until ready (valid/ready rule).
- BUSY_EMU:
  - ram_rd_strobe → rd_data registered, emu_rd_strobe 1 cycle later.
  - emu_abort → ram_cmd_abort=1, held until ram_done → DRAIN.
  - ram_done without abort → DRAIN.
- BUSY_HOST:
  - Reads as for emu, but strobes go to host_rd_strobe.
  - Writes: host_wr_take = ram_wr_take, same cycle.
  - ram_done → DRAIN.
- DRAIN: one cycle. Deassert grant, pulse the owner's done, → IDLE. Late ram_rd_strobe in DRAIN/IDLE is ignored.
- Grant is exclusive: emu_grant and host_grant are never both 1.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, each cycle host_req=1 and host_grant=0 while emu holds grant.
  - Clears when host_grant rises.
  - Simultaneous emu_req and host_req in IDLE with counter saturated → host wins.
- emu_abort while not emu-granted: ignored.
- An emu request arriving during BUSY_HOST waits; no preemption.

Optional Feature:
- SPI_RAM_ARB_STATS_EN. When defined, add output ports:
  - stat_emu_grants [15:0]: saturating count of emu grants;
  - stat_host_grants [15:0]: saturating count of host grants;
  - stat_starve_forced [15:0]: saturating count of starvation overrides;
  - stat_max_emu_wait [15:0]: max cycles from emu_req rise to ram_cmd_valid.
- All stat counters clear on reset. When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Emu read, addr 0x012345: cmd_ready after 2 cycles; 4 ram_rd_strobes; emu_abort → cmd addr 0x012345, len 0, 4 emu_rd_strobes each 1 cycle after source; ram_cmd_abort held until ram_done; emu_done 1 cycle after.
- Host write, addr 0x000100, len 3, bytes A5,5A,FF → ram_cmd_write=1, len 3; host_wr_take mirrors 3 ram_wr_take; host_done after ram_done+1.
- emu_req and host_req same cycle, counter 0 → emu granted. Hold host_req for STARVE_LIMIT cycles of back-to-back emu → next IDLE decision grants host although emu_req=1.
- emu_abort while cmd_ready=0 in ISSUE_EMU → no accepted command; emu_done pulse; returns IDLE.
- host_len=0 → no ram_cmd_valid; host_done 1 cycle after grant.
- reset_n low during BUSY_HOST → all outputs 0 asynchronously; after release, IDLE, counter 0; new emu_req served normally.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// spi_ram_arbiter
//
// Shares one QSPI RAM command port between two requesters:
//   emu  - flash-emulation read stream. It has fixed priority, is read-only and
//          stays open (len 0) until the flash chip-select ends it via emu_abort.
//   host - bounded host/UART reads and writes used to load or inspect the image.
// A starvation counter forces one host grant after STARVE_LIMIT cycles of host
// waiting while emu owns the port.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   emu_req/emu_addr/emu_abort        emu request level, start address, stream end
//   emu_grant/emu_rd_strobe/emu_done  emu ownership, read byte valid, retire pulse
//   host_req/addr/len/write/wr_data   host request level and transfer description
//   host_grant/rd_strobe/wr_take/done host ownership, read valid, write consume, retire
//   rd_data                           registered read byte shared by both requesters
//   ram_cmd_*                         command to the RAM sequencer (valid/ready)
//   ram_rd_data/rd_strobe/wr_take/done  sequencer data and completion
//   ram_wr_data                       combinational pass-through of host_wr_data
//
// Build option
//   SPI_RAM_ARB_STATS_EN - adds saturating grant/override counters and the
//                          worst observed emu request-to-command latency.
// -----------------------------------------------------------------------------
module spi_ram_arbiter #(
    parameter int ADDR_BITS    = 24,
    parameter int LEN_BITS     = 16,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 emu_req,
    input  logic [ADDR_BITS-1:0] emu_addr,
    input  logic                 emu_abort,
    output logic                 emu_grant,
    output logic                 emu_rd_strobe,
    output logic                 emu_done,
    input  logic                 host_req,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [LEN_BITS-1:0]  host_len,
    input  logic                 host_write,
    input  logic [7:0]           host_wr_data,
    output logic                 host_grant,
    output logic                 host_rd_strobe,
    output logic                 host_wr_take,
    output logic                 host_done,
    output logic [7:0]           rd_data,
    output logic                 ram_cmd_valid,
    input  logic                 ram_cmd_ready,
    output logic [ADDR_BITS-1:0] ram_cmd_addr,
    output logic [LEN_BITS-1:0]  ram_cmd_len,
    output logic                 ram_cmd_write,
    output logic                 ram_cmd_abort,
    input  logic [7:0]           ram_rd_data,
    input  logic                 ram_rd_strobe,
    input  logic                 ram_wr_take,
    output logic [7:0]           ram_wr_data,
    input  logic                 ram_done
`ifdef SPI_RAM_ARB_STATS_EN
    ,
    output logic [15:0]          stat_emu_grants,
    output logic [15:0]          stat_host_grants,
    output logic [15:0]          stat_starve_forced,
    output logic [15:0]          stat_max_emu_wait
`endif
);

    localparam int STARVE_BITS = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_BITS-1:0] STARVE_MAX = STARVE_BITS'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE_EMU  = 3'd1,
        ST_ISSUE_HOST = 3'd2,
        ST_BUSY_EMU   = 3'd3,
        ST_BUSY_HOST  = 3'd4,
        ST_DRAIN      = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;

    logic                   emu_grant_r;
    logic                   host_grant_r;
    logic                   cmd_valid_r;
    logic                   cmd_abort_r;
    logic [ADDR_BITS-1:0]   cmd_addr_r;
    logic [LEN_BITS-1:0]    cmd_len_r;
    logic                   cmd_write_r;
    logic                   emu_done_r;
    logic                   host_done_r;
    logic                   emu_rd_strobe_r;
    logic                   host_rd_strobe_r;
    logic [7:0]             rd_data_r;
    logic [STARVE_BITS-1:0] starve_r;

    logic                   emu_grant_s;
    logic                   host_grant_s;
    logic                   cmd_valid_s;
    logic                   cmd_abort_s;
    logic [ADDR_BITS-1:0]   cmd_addr_s;
    logic [LEN_BITS-1:0]    cmd_len_s;
    logic                   cmd_write_s;
    logic                   emu_done_s;
    logic                   host_done_s;
    logic                   starve_force_s;
    logic                   emu_req_ok_s;
    logic                   host_req_ok_s;
    logic                   starve_full_s;
    logic                   emu_rd_hit_s;
    logic                   host_rd_hit_s;

    // A requester whose done pulse is visible this cycle is still dropping its
    // level request; masking it prevents re-granting a retired transaction.
    assign emu_req_ok_s  = emu_req & ~emu_done_r;
    assign host_req_ok_s = host_req & ~host_done_r;
    assign starve_full_s = (starve_r == STARVE_MAX);

    // Read bytes are only forwarded while a read transfer is actually busy;
    // late strobes in DRAIN/IDLE fall through here.
    assign emu_rd_hit_s  = ram_rd_strobe & (state_r == ST_BUSY_EMU);
    assign host_rd_hit_s = ram_rd_strobe & (state_r == ST_BUSY_HOST) & ~cmd_write_r;

    // Next-state and next-output decode; all outputs below are registered from these.
    always_comb begin
        next_state_s   = state_r;
        cmd_valid_s    = 1'b0;
        cmd_abort_s    = cmd_abort_r;
        cmd_addr_s     = cmd_addr_r;
        cmd_len_s      = cmd_len_r;
        cmd_write_s    = cmd_write_r;
        emu_done_s     = 1'b0;
        host_done_s    = 1'b0;
        starve_force_s = 1'b0;
        emu_grant_s    = 1'b0;
        host_grant_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (emu_req_ok_s && !(host_req_ok_s && starve_full_s)) begin
                    next_state_s = ST_ISSUE_EMU;
                    cmd_valid_s  = 1'b1;
                    cmd_addr_s   = emu_addr;
                    cmd_len_s    = {LEN_BITS{1'b0}};
                    cmd_write_s  = 1'b0;
                end else if (host_req_ok_s) begin
                    next_state_s   = ST_ISSUE_HOST;
                    // A zero-length host transfer never reaches the RAM.
                    cmd_valid_s    = (host_len != {LEN_BITS{1'b0}});
                    cmd_addr_s     = host_addr;
                    cmd_len_s      = host_len;
                    cmd_write_s    = host_write;
                    starve_force_s = emu_req_ok_s;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE_EMU: begin
                if (ram_cmd_ready) begin
                    // An abort coinciding with acceptance must still end the
                    // now-open stream, so it is carried into BUSY_EMU.
                    next_state_s = ST_BUSY_EMU;
                    cmd_abort_s  = emu_abort;
                end else if (emu_abort) begin
                    next_state_s = ST_IDLE;
                    emu_done_s   = 1'b1;
                end else begin
                    cmd_valid_s = 1'b1;
                end
            end
            ST_ISSUE_HOST: begin
                if (cmd_len_r == {LEN_BITS{1'b0}}) begin
                    next_state_s = ST_IDLE;
                    host_done_s  = 1'b1;
                end else if (ram_cmd_ready) begin
                    next_state_s = ST_BUSY_HOST;
                end else begin
                    cmd_valid_s = 1'b1;
                end
            end
            ST_BUSY_EMU: begin
                if (ram_done) begin
                    next_state_s = ST_DRAIN;
                    cmd_abort_s  = 1'b0;
                    emu_done_s   = 1'b1;
                end else if (emu_abort) begin
                    cmd_abort_s = 1'b1;
                end else begin
                    cmd_abort_s = cmd_abort_r;
                end
            end
            ST_BUSY_HOST: begin
                if (ram_done) begin
                    next_state_s = ST_DRAIN;
                    host_done_s  = 1'b1;
                end else begin
                    next_state_s = ST_BUSY_HOST;
                end
            end
            ST_DRAIN: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
                cmd_abort_s  = 1'b0;
            end
        endcase

        emu_grant_s  = (next_state_s == ST_ISSUE_EMU)  || (next_state_s == ST_BUSY_EMU);
        host_grant_s = (next_state_s == ST_ISSUE_HOST) || (next_state_s == ST_BUSY_HOST);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            emu_grant_r      <= 1'b0;
            host_grant_r     <= 1'b0;
            cmd_valid_r      <= 1'b0;
            cmd_abort_r      <= 1'b0;
            cmd_addr_r       <= {ADDR_BITS{1'b0}};
            cmd_len_r        <= {LEN_BITS{1'b0}};
            cmd_write_r      <= 1'b0;
            emu_done_r       <= 1'b0;
            host_done_r      <= 1'b0;
            emu_rd_strobe_r  <= 1'b0;
            host_rd_strobe_r <= 1'b0;
            rd_data_r        <= 8'h00;
        end else begin
            state_r          <= next_state_s;
            emu_grant_r      <= emu_grant_s;
            host_grant_r     <= host_grant_s;
            cmd_valid_r      <= cmd_valid_s;
            cmd_abort_r      <= cmd_abort_s;
            cmd_addr_r       <= cmd_addr_s;
            cmd_len_r        <= cmd_len_s;
            cmd_write_r      <= cmd_write_s;
            emu_done_r       <= emu_done_s;
            host_done_r      <= host_done_s;
            emu_rd_strobe_r  <= emu_rd_hit_s;
            host_rd_strobe_r <= host_rd_hit_s;
            if (emu_rd_hit_s || host_rd_hit_s) begin
                rd_data_r <= ram_rd_data;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    // Starvation counter: counts host wait cycles while emu owns the port,
    // cleared the cycle host ownership begins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_r <= {STARVE_BITS{1'b0}};
        end else if (host_grant_s && !host_grant_r) begin
            starve_r <= {STARVE_BITS{1'b0}};
        end else if (host_req && !host_grant_r && emu_grant_r && !starve_full_s) begin
            starve_r <= starve_r + STARVE_BITS'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    assign emu_grant      = emu_grant_r;
    assign host_grant     = host_grant_r;
    assign emu_done       = emu_done_r;
    assign host_done      = host_done_r;
    assign emu_rd_strobe  = emu_rd_strobe_r;
    assign host_rd_strobe = host_rd_strobe_r;
    assign rd_data        = rd_data_r;
    assign ram_cmd_valid  = cmd_valid_r;
    assign ram_cmd_abort  = cmd_abort_r;
    assign ram_cmd_addr   = cmd_addr_r;
    assign ram_cmd_len    = cmd_len_r;
    assign ram_cmd_write  = cmd_write_r;
    // Write handshake is same-cycle with the sequencer, so it is decoded from
    // registered state rather than delayed.
    assign host_wr_take   = ram_wr_take & (state_r == ST_BUSY_HOST) & cmd_write_r;
    assign ram_wr_data    = host_wr_data;

`ifdef SPI_RAM_ARB_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    logic [15:0] stat_emu_grants_r;
    logic [15:0] stat_host_grants_r;
    logic [15:0] stat_starve_forced_r;
    logic [15:0] stat_max_emu_wait_r;
    logic        emu_req_d_r;
    logic        emu_wait_act_r;
    logic [15:0] emu_wait_cnt_r;
    logic        emu_req_rise_s;
    logic        emu_issue_s;
    logic [15:0] cur_wait_s;

    assign emu_req_rise_s = emu_req & ~emu_req_d_r;
    assign emu_issue_s    = (state_r == ST_IDLE) && (next_state_s == ST_ISSUE_EMU);
    // Latency counted inclusive, so a same-cycle decision reads as 1 cycle
    // (cmd_valid appears one edge after the request is seen).
    assign cur_wait_s     = emu_req_rise_s ? 16'd1 : sat_inc16(emu_wait_cnt_r);

    // Statistics counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_emu_grants_r    <= 16'h0000;
            stat_host_grants_r   <= 16'h0000;
            stat_starve_forced_r <= 16'h0000;
            stat_max_emu_wait_r  <= 16'h0000;
            emu_req_d_r          <= 1'b0;
            emu_wait_act_r       <= 1'b0;
            emu_wait_cnt_r       <= 16'h0000;
        end else begin
            emu_req_d_r <= emu_req;
            if (emu_grant_s && !emu_grant_r) begin
                stat_emu_grants_r <= sat_inc16(stat_emu_grants_r);
            end
            if (host_grant_s && !host_grant_r) begin
                stat_host_grants_r <= sat_inc16(stat_host_grants_r);
            end
            if (starve_force_s) begin
                stat_starve_forced_r <= sat_inc16(stat_starve_forced_r);
            end
            if (emu_issue_s) begin
                emu_wait_act_r <= 1'b0;
                emu_wait_cnt_r <= cur_wait_s;
                if (cur_wait_s > stat_max_emu_wait_r) begin
                    stat_max_emu_wait_r <= cur_wait_s;
                end
            end else if (emu_req_rise_s || emu_wait_act_r) begin
                emu_wait_act_r <= 1'b1;
                emu_wait_cnt_r <= cur_wait_s;
            end
        end
    end

    assign stat_emu_grants    = stat_emu_grants_r;
    assign stat_host_grants   = stat_host_grants_r;
    assign stat_starve_forced = stat_starve_forced_r;
    assign stat_max_emu_wait  = stat_max_emu_wait_r;
`endif

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed self-checking bench for spi_ram_arbiter (default build).
module tb_spi_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        emu_req;
    logic [23:0] emu_addr;
    logic        emu_abort;
    logic        emu_grant;
    logic        emu_rd_strobe;
    logic        emu_done;
    logic        host_req;
    logic [23:0] host_addr;
    logic [15:0] host_len;
    logic        host_write;
    logic [7:0]  host_wr_data;
    logic        host_grant;
    logic        host_rd_strobe;
    logic        host_wr_take;
    logic        host_done;
    logic [7:0]  rd_data;
    logic        ram_cmd_valid;
    logic        ram_cmd_ready;
    logic [23:0] ram_cmd_addr;
    logic [15:0] ram_cmd_len;
    logic        ram_cmd_write;
    logic        ram_cmd_abort;
    logic [7:0]  ram_rd_data;
    logic        ram_rd_strobe;
    logic        ram_wr_take;
    logic [7:0]  ram_wr_data;
    logic        ram_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] emu_bytes  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] wr_bytes   [3] = '{8'hA5, 8'h5A, 8'hFF};
    logic [7:0] host_bytes [2] = '{8'hC3, 8'h3C};

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_BITS(24), .LEN_BITS(16), .STARVE_LIMIT(1024)) dut (
        .clk(clk), .reset_n(reset_n),
        .emu_req(emu_req), .emu_addr(emu_addr), .emu_abort(emu_abort),
        .emu_grant(emu_grant), .emu_rd_strobe(emu_rd_strobe), .emu_done(emu_done),
        .host_req(host_req), .host_addr(host_addr), .host_len(host_len),
        .host_write(host_write), .host_wr_data(host_wr_data),
        .host_grant(host_grant), .host_rd_strobe(host_rd_strobe),
        .host_wr_take(host_wr_take), .host_done(host_done),
        .rd_data(rd_data),
        .ram_cmd_valid(ram_cmd_valid), .ram_cmd_ready(ram_cmd_ready),
        .ram_cmd_addr(ram_cmd_addr), .ram_cmd_len(ram_cmd_len),
        .ram_cmd_write(ram_cmd_write), .ram_cmd_abort(ram_cmd_abort),
        .ram_rd_data(ram_rd_data), .ram_rd_strobe(ram_rd_strobe),
        .ram_wr_take(ram_wr_take), .ram_wr_data(ram_wr_data),
        .ram_done(ram_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; emu_req = 1'b0; emu_addr = 24'h0; emu_abort = 1'b0;
        host_req = 1'b0; host_addr = 24'h0; host_len = 16'h0; host_write = 1'b0;
        host_wr_data = 8'h00; ram_cmd_ready = 1'b0; ram_rd_data = 8'h00;
        ram_rd_strobe = 1'b0; ram_wr_take = 1'b0; ram_done = 1'b0;

        // Reset state
        step(); step();
        chk("rst_emu_grant",  32'(emu_grant),     32'd0);
        chk("rst_host_grant", 32'(host_grant),    32'd0);
        chk("rst_cmd_valid",  32'(ram_cmd_valid), 32'd0);
        chk("rst_cmd_abort",  32'(ram_cmd_abort), 32'd0);
        chk("rst_done",       32'({emu_done, host_done}), 32'd0);
        chk("rst_rd_data",    32'(rd_data),       32'd0);
        chk("rst_cmd_addr",   32'(ram_cmd_addr),  32'd0);
        chk("rst_cmd_len",    32'(ram_cmd_len),   32'd0);
        reset_n = 1'b1;
        step();
        chk("idle_grants", 32'({emu_grant, host_grant}), 32'd0);

        // Emu open-ended read with abort
        emu_req = 1'b1; emu_addr = 24'h012345;
        step();
        chk("t1_emu_grant",  32'(emu_grant),     32'd1);
        chk("t1_host_grant", 32'(host_grant),    32'd0);
        chk("t1_valid",      32'(ram_cmd_valid), 32'd1);
        chk("t1_addr",       32'(ram_cmd_addr),  32'h012345);
        chk("t1_len",        32'(ram_cmd_len),   32'd0);
        chk("t1_write",      32'(ram_cmd_write), 32'd0);
        step();
        chk("t1_valid_held", 32'(ram_cmd_valid), 32'd1);
        chk("t1_addr_held",  32'(ram_cmd_addr),  32'h012345);
        ram_cmd_ready = 1'b1;
        step();
        ram_cmd_ready = 1'b0;
        chk("t1_valid_drop", 32'(ram_cmd_valid), 32'd0);
        chk("t1_busy_grant", 32'(emu_grant),     32'd1);
        for (int i = 0; i < 4; i++) begin
            ram_rd_strobe = 1'b1; ram_rd_data = emu_bytes[i];
            step();
            chk("t1_emu_strobe",   32'(emu_rd_strobe),  32'd1);
            chk("t1_rd_data",      32'(rd_data),        32'(emu_bytes[i]));
            chk("t1_host_strobe",  32'(host_rd_strobe), 32'd0);
        end
        ram_rd_strobe = 1'b0;
        step();
        chk("t1_strobe_end", 32'(emu_rd_strobe), 32'd0);
        emu_abort = 1'b1;
        step();
        emu_abort = 1'b0;
        chk("t1_abort",      32'(ram_cmd_abort), 32'd1);
        step();
        chk("t1_abort_held", 32'(ram_cmd_abort), 32'd1);
        chk("t1_no_done",    32'(emu_done),      32'd0);
        ram_done = 1'b1;
        step();
        ram_done = 1'b0;
        chk("t1_done",       32'(emu_done),      32'd1);
        chk("t1_grant_off",  32'(emu_grant),     32'd0);
        chk("t1_abort_off",  32'(ram_cmd_abort), 32'd0);
        emu_req = 1'b0; ram_rd_strobe = 1'b1; ram_rd_data = 8'h99;
        step();
        ram_rd_strobe = 1'b0;
        chk("t1_done_pulse", 32'(emu_done),      32'd0);
        chk("t1_late_strobe", 32'(emu_rd_strobe), 32'd0);
        chk("t1_late_data",  32'(rd_data),       32'h44);

        // Host write of three bytes
        host_req = 1'b1; host_addr = 24'h000100; host_len = 16'd3; host_write = 1'b1;
        step();
        chk("t2_host_grant", 32'(host_grant),    32'd1);
        chk("t2_emu_grant",  32'(emu_grant),     32'd0);
        chk("t2_valid",      32'(ram_cmd_valid), 32'd1);
        chk("t2_write",      32'(ram_cmd_write), 32'd1);
        chk("t2_len",        32'(ram_cmd_len),   32'd3);
        chk("t2_addr",       32'(ram_cmd_addr),  32'h000100);
        ram_cmd_ready = 1'b1;
        step();
        ram_cmd_ready = 1'b0;
        chk("t2_valid_drop", 32'(ram_cmd_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            host_wr_data = wr_bytes[i];
            #1;
            chk("t2_take_idle", 32'(host_wr_take), 32'd0);
            chk("t2_wr_data",   32'(ram_wr_data),  32'(wr_bytes[i]));
            ram_wr_take = 1'b1;
            #1;
            chk("t2_take",      32'(host_wr_take), 32'd1);
            step();
            ram_wr_take = 1'b0;
        end
        ram_done = 1'b1;
        step();
        ram_done = 1'b0;
        chk("t2_done",      32'(host_done),  32'd1);
        chk("t2_grant_off", 32'(host_grant), 32'd0);
        host_req = 1'b0; host_write = 1'b0;
        step();
        chk("t2_done_pulse", 32'(host_done), 32'd0);

        // Simultaneous requests, then starvation override
        emu_req = 1'b1; emu_addr = 24'h000400;
        host_req = 1'b1; host_addr = 24'h000200; host_len = 16'd2; host_write = 1'b0;
        step();
        chk("t3_emu_first",  32'(emu_grant),  32'd1);
        chk("t3_host_wait",  32'(host_grant), 32'd0);
        ram_cmd_ready = 1'b1;
        step();
        ram_cmd_ready = 1'b0;
        repeat (5) step();
        ram_done = 1'b1;
        step();
        ram_done = 1'b0;
        chk("t3_emu_done1", 32'(emu_done), 32'd1);
        step();
        step();
        chk("t3_emu_again", 32'(emu_grant),  32'd1);
        chk("t3_host_still", 32'(host_grant), 32'd0);
        ram_cmd_ready = 1'b1;
        step();
        ram_cmd_ready = 1'b0;
        repeat (1100) step();
        ram_done = 1'b1;
        step();
        ram_done = 1'b0;
        chk("t3_emu_done2", 32'(emu_done), 32'd1);
        step();
        chk("t3_idle", 32'({emu_grant, host_grant}), 32'd0);
        step();
        chk("t3_host_forced", 32'(host_grant),    32'd1);
        chk("t3_emu_denied",  32'(emu_grant),     32'd0);
        chk("t3_valid",       32'(ram_cmd_valid), 32'd1);
        chk("t3_len",         32'(ram_cmd_len),   32'd2);
        chk("t3_write",       32'(ram_cmd_write), 32'd0);
        chk("t3_addr",        32'(ram_cmd_addr),  32'h000200);
        ram_cmd_ready = 1'b1;
        step();
        ram_cmd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ram_rd_strobe = 1'b1; ram_rd_data = host_bytes[i];
            step();
            chk("t3_host_strobe", 32'(host_rd_strobe), 32'd1);
            chk("t3_emu_strobe",  32'(emu_rd_strobe),  32'd0);
            chk("t3_rd_data",     32'(rd_data),        32'(host_bytes[i]));
            chk("t3_no_preempt",  32'(emu_grant),      32'd0);
        end
        ram_rd_strobe = 1'b0; ram_done = 1'b1;
        step();
        ram_done = 1'b0;
        chk("t3_host_done", 32'(host_done), 32'd1);
        host_req = 1'b0;
        step();
        step();
        chk("t3_emu_served", 32'(emu_grant),    32'd1);
        chk("t3_emu_addr",   32'(ram_cmd_addr), 32'h000400);

        // Emu abort before the command is accepted
        emu_abort = 1'b1;
        step();
        emu_abort = 1'b0;
        chk("t4_done",       32'(emu_done),      32'd1);
        chk("t4_grant_off",  32'(emu_grant),     32'd0);
        chk("t4_valid_off",  32'(ram_cmd_valid), 32'd0);
        chk("t4_no_abort",   32'(ram_cmd_abort), 32'd0);
        emu_req = 1'b0;
        step();
        chk("t4_done_pulse", 32'(emu_done),  32'd0);
        chk("t4_idle",       32'(emu_grant), 32'd0);
        emu_abort = 1'b1;
        step();
        emu_abort = 1'b0;
        chk("t4_abort_ignored", 32'({ram_cmd_abort, emu_done, emu_grant}), 32'd0);

        // Zero-length host request
        host_req = 1'b1; host_addr = 24'h000500; host_len = 16'd0; host_write = 1'b1;
        step();
        chk("t5_grant",     32'(host_grant),    32'd1);
        chk("t5_no_valid",  32'(ram_cmd_valid), 32'd0);
        step();
        chk("t5_done",      32'(host_done),     32'd1);
        chk("t5_grant_off", 32'(host_grant),    32'd0);
        chk("t5_no_valid2", 32'(ram_cmd_valid), 32'd0);
        host_req = 1'b0; host_write = 1'b0;
        step();
        chk("t5_done_pulse", 32'(host_done), 32'd0);

        // Asynchronous reset during a host read
        host_req = 1'b1; host_addr = 24'h000300; host_len = 16'd4;
        step();
        chk("t6_grant", 32'(host_grant), 32'd1);
        ram_cmd_ready = 1'b1;
        step();
        ram_cmd_ready = 1'b0;
        ram_rd_strobe = 1'b1; ram_rd_data = 8'h77;
        step();
        ram_rd_strobe = 1'b0;
        chk("t6_strobe", 32'(host_rd_strobe), 32'd1);
        chk("t6_data",   32'(rd_data),        32'h77);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_grant",  32'(host_grant),     32'd0);
        chk("t6_rst_strobe", 32'(host_rd_strobe), 32'd0);
        chk("t6_rst_data",   32'(rd_data),        32'd0);
        chk("t6_rst_len",    32'(ram_cmd_len),    32'd0);
        chk("t6_rst_addr",   32'(ram_cmd_addr),   32'd0);
        host_req = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("t6_idle", 32'({emu_grant, host_grant, ram_cmd_valid}), 32'd0);
        emu_req = 1'b1; emu_addr = 24'h000ABC;
        step();
        chk("t6_emu_grant", 32'(emu_grant),     32'd1);
        chk("t6_emu_valid", 32'(ram_cmd_valid), 32'd1);
        chk("t6_emu_addr",  32'(ram_cmd_addr),  32'h000ABC);
        ram_cmd_ready = 1'b1;
        step();
        ram_cmd_ready = 1'b0; ram_done = 1'b1;
        step();
        ram_done = 1'b0;
        chk("t6_emu_done", 32'(emu_done), 32'd1);
        emu_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
